// File: rtl/icache.sv
// icache: direct-mapped instruction cache sitting between the fetcher and
// memCtrl. A hit answers one cycle after the request. A miss refills a whole
// line, one word per memCtrl round trip, and then answers. A mispredict flush
// aborts any refill in progress and leaves the partial line invalid.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rdy             global ready; every register holds while low
//   in_fetch_flag   fetch request valid (sampled only in IDLE)
//   in_fetch_pc     word-aligned instruction address
//   out_fetch_flag  one-cycle pulse, out_fetch_inst valid
//   out_fetch_inst  instruction word
//   out_mem_flag    word-read request to memCtrl, held until in_mem_flag
//   out_mem_addr    word address of the current refill beat
//   in_mem_flag     one-cycle pulse, in_mem_data valid
//   in_mem_data     word returned by memCtrl
//   in_rob_xbp      mispredict flush
module icache #(
  parameter int INDEX_WIDTH    = 6,
  parameter int LINE_WORDS_LOG = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_fetch_flag,
  input  logic [31:0] in_fetch_pc,
  output logic        out_fetch_flag,
  output logic [31:0] out_fetch_inst,
  output logic        out_mem_flag,
  output logic [31:0] out_mem_addr,
  input  logic        in_mem_flag,
  input  logic [31:0] in_mem_data,
  input  logic        in_rob_xbp
);

  localparam int LINES  = 1 << INDEX_WIDTH;
  localparam int WORDS  = 1 << LINE_WORDS_LOG;
  localparam int IDX_LO = 2 + LINE_WORDS_LOG;
  localparam int TAG_LO = IDX_LO + INDEX_WIDTH;
  localparam int TAG_W  = 32 - TAG_LO;

  typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

  state_t                    state;
  logic [LINES-1:0]          valid;
  logic [TAG_W-1:0]          tag_mem  [LINES];
  logic [31:0]               data_mem [LINES][WORDS];

  logic [TAG_W-1:0]          req_tag;
  logic [INDEX_WIDTH-1:0]    req_index;
  logic [LINE_WORDS_LOG-1:0] req_offset;
  logic [LINE_WORDS_LOG-1:0] beat;

  logic [TAG_W-1:0]          pc_tag;
  logic [INDEX_WIDTH-1:0]    pc_index;
  logic [LINE_WORDS_LOG-1:0] pc_offset;
  logic                      pc_hit;
  logic                      mem_we;
  logic                      unused_pc_bits;

  // Byte-offset bits of the pc carry no information for word fetches.
  assign unused_pc_bits = ^in_fetch_pc[1:0];

  assign pc_tag    = in_fetch_pc[31:TAG_LO];
  assign pc_index  = in_fetch_pc[TAG_LO-1:IDX_LO];
  assign pc_offset = in_fetch_pc[IDX_LO-1:2];
  assign pc_hit    = valid[pc_index] && (tag_mem[pc_index] == pc_tag);

  // A beat is written only when it actually advances the refill; a beat that
  // coincides with reset, a stall or a flush is dropped.
  assign mem_we = rdy && !rst && !in_rob_xbp && (state == REFILL) && in_mem_flag;

  // Line storage has no reset: valid bits alone decide whether it is trusted.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      data_mem[req_index][beat] <= in_mem_data;
      if (&beat) begin
        tag_mem[req_index] <= req_tag;
      end
    end
  end

  // Controller: all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      valid          <= '0;
      beat           <= '0;
      req_tag        <= '0;
      req_index      <= '0;
      req_offset     <= '0;
      out_fetch_flag <= 1'b0;
      out_fetch_inst <= 32'd0;
      out_mem_flag   <= 1'b0;
      out_mem_addr   <= 32'd0;
    end else if (rdy) begin
      if (in_rob_xbp) begin
        // The line being refilled was already invalidated on the miss.
        state          <= IDLE;
        out_mem_flag   <= 1'b0;
        out_fetch_flag <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            out_fetch_flag <= 1'b0;
            if (in_fetch_flag) begin
              req_tag    <= pc_tag;
              req_index  <= pc_index;
              req_offset <= pc_offset;
              if (pc_hit) begin
                out_fetch_flag <= 1'b1;
                out_fetch_inst <= data_mem[pc_index][pc_offset];
              end else begin
                valid[pc_index] <= 1'b0;
                state           <= REFILL;
                beat            <= '0;
                out_mem_flag    <= 1'b1;
                out_mem_addr    <= {in_fetch_pc[31:IDX_LO], {IDX_LO{1'b0}}};
              end
            end
          end
          REFILL: begin
            if (in_mem_flag) begin
              if (&beat) begin
                // Last word lands in the array this same edge, so bypass it.
                valid[req_index] <= 1'b1;
                out_mem_flag     <= 1'b0;
                out_fetch_flag   <= 1'b1;
                out_fetch_inst   <= (req_offset == beat) ? in_mem_data
                                                         : data_mem[req_index][req_offset];
                state            <= RESPOND;
              end else begin
                beat         <= beat + 1'b1;
                out_mem_addr <= out_mem_addr + 32'd4;
              end
            end
          end
          RESPOND: begin
            out_fetch_flag <= 1'b0;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: self-checking bench for icache. Expected instructions are queued
// when a fetch is issued and compared when out_fetch_flag appears; refill
// beats are served by a small memory model inside the bench.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_fetch_flag;
  logic [31:0] in_fetch_pc;
  logic        out_fetch_flag;
  logic [31:0] out_fetch_inst;
  logic        out_mem_flag;
  logic [31:0] out_mem_addr;
  logic        in_mem_flag;
  logic [31:0] in_mem_data;
  logic        in_rob_xbp;

  int          checkCount = 0;
  int          passCount  = 0;
  int          respCount  = 0;
  int          respBefore;
  logic [31:0] sbQueue[$];
  logic [31:0] expInst;
  logic [31:0] dropped;

  icache dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .in_fetch_flag  (in_fetch_flag),
    .in_fetch_pc    (in_fetch_pc),
    .out_fetch_flag (out_fetch_flag),
    .out_fetch_inst (out_fetch_inst),
    .out_mem_flag   (out_mem_flag),
    .out_mem_addr   (out_mem_addr),
    .in_mem_flag    (in_mem_flag),
    .in_mem_data    (in_mem_data),
    .in_rob_xbp     (in_rob_xbp)
  );

  always #5 clk = ~clk;

  // Backing memory contents seen through memCtrl.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'hC:   return 32'h44;
      default: return addr ^ 32'hA5A5_0000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  // Response monitor: every out_fetch_flag pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_fetch_flag === 1'b1) begin
      respCount++;
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_resp", 32'd1, 32'd0);
      end else begin
        expInst = sbQueue.pop_front();
        checkOutput("fetch_inst", out_fetch_inst, expInst);
      end
    end
  end

  // Issue one fetch and check the first-cycle reaction (hit pulse or refill start).
  task automatic applyStimulus(input logic [31:0] pc, input bit expectHit);
    in_fetch_flag = 1'b1;
    in_fetch_pc   = pc;
    sbQueue.push_back(memWord(pc));
    @(negedge clk);
    in_fetch_flag = 1'b0;
    if (expectHit) begin
      checkOutput("hit_flag", {31'b0, out_fetch_flag}, 32'd1);
      checkOutput("hit_no_mem", {31'b0, out_mem_flag}, 32'd0);
    end else begin
      checkOutput("miss_req", {31'b0, out_mem_flag}, 32'd1);
      checkOutput("miss_base", out_mem_addr, {pc[31:4], 4'b0});
      checkOutput("miss_no_resp", {31'b0, out_fetch_flag}, 32'd0);
    end
  endtask

  task automatic serveBeat(input logic [31:0] addr, input bit withFlush);
    checkOutput("beat_addr", out_mem_addr, addr);
    checkOutput("beat_req", {31'b0, out_mem_flag}, 32'd1);
    in_mem_flag = 1'b1;
    in_mem_data = memWord(addr);
    in_rob_xbp  = withFlush;
    @(negedge clk);
    in_mem_flag = 1'b0;
    in_mem_data = 32'd0;
    in_rob_xbp  = 1'b0;
  endtask

  task automatic stallCycles(input int n, input logic [31:0] addr);
    rdy = 1'b0;
    repeat (n) begin
      @(negedge clk);
      checkOutput("stall_addr", out_mem_addr, addr);
      checkOutput("stall_req", {31'b0, out_mem_flag}, 32'd1);
    end
    rdy = 1'b1;
  endtask

  // Serve all four beats; stallBeat < 0 means no rdy stall.
  task automatic serveLine(input logic [31:0] base, input int stallBeat);
    for (int b = 0; b < 4; b++) begin
      if (b == stallBeat) stallCycles(5, base + 32'(4 * b));
      serveBeat(base + 32'(4 * b), 1'b0);
    end
    checkOutput("refill_req_drop", {31'b0, out_mem_flag}, 32'd0);
    checkOutput("respond_flag", {31'b0, out_fetch_flag}, 32'd1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_fflag"}, {31'b0, out_fetch_flag}, 32'd0);
    checkOutput({tag, "_finst"}, out_fetch_inst, 32'd0);
    checkOutput({tag, "_mflag"}, {31'b0, out_mem_flag}, 32'd0);
    checkOutput({tag, "_maddr"}, out_mem_addr, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; in_fetch_flag = 1'b0; in_fetch_pc = 32'd0;
    in_mem_flag = 1'b0; in_mem_data = 32'd0; in_rob_xbp = 1'b0;
    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Cold miss on 0x8 refills 0x0..0xC and answers 0x33.
    applyStimulus(32'h8, 1'b0);
    serveLine(32'h0, -1);
    @(negedge clk);

    // Warm hits on the same line.
    applyStimulus(32'h0, 1'b1);
    @(negedge clk);
    applyStimulus(32'hC, 1'b1);
    @(negedge clk);

    // Conflict eviction at index 0, then the old line misses again.
    applyStimulus(32'h400, 1'b0);
    serveLine(32'h400, -1);
    @(negedge clk);
    applyStimulus(32'h0, 1'b0);
    serveLine(32'h0, -1);
    @(negedge clk);

    // Flush during beat 2 with in_mem_flag coincident.
    applyStimulus(32'h10, 1'b0);
    serveBeat(32'h10, 1'b0);
    serveBeat(32'h14, 1'b0);
    respBefore = respCount;
    serveBeat(32'h18, 1'b1);
    dropped = sbQueue.pop_back();
    checkOutput("flush_req_drop", {31'b0, out_mem_flag}, 32'd0);
    checkOutput("flush_no_resp", {31'b0, out_fetch_flag}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("flush_resp_count", 32'(respCount), 32'(respBefore));
    applyStimulus(32'h10, 1'b0);
    serveLine(32'h10, -1);
    @(negedge clk);

    // rdy stall before beat 2; offset 3 exercises the last-word bypass.
    applyStimulus(32'h2C, 1'b0);
    serveLine(32'h20, 2);
    @(negedge clk);
    applyStimulus(32'h28, 1'b1);
    @(negedge clk);

    // Reset in the middle of a refill invalidates previously hit lines.
    applyStimulus(32'h0, 1'b1);
    @(negedge clk);
    applyStimulus(32'h30, 1'b0);
    serveBeat(32'h30, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkIdleOutputs("midreset");
    rst = 1'b0;
    dropped = sbQueue.pop_back();
    @(negedge clk);
    applyStimulus(32'h0, 1'b0);
    serveLine(32'h0, -1);
    @(negedge clk);
    @(negedge clk);

    checkOutput("sb_empty", 32'(sbQueue.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache between the fetcher and memCtrl.
- On a hit, returns the 32-bit instruction one cycle after the request.
- On a miss, refills a 4-word line through memCtrl's word-fetch port, then responds.
- Branch mispredict (in_rob_xbp) aborts any refill in progress without polluting the cache.

Parameters:
INDEX_WIDTH, 6, log2 of line count (64 lines)
LINE_WORDS_LOG, 2, log2 of words per line (4 words = 16 bytes)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; all state frozen when low
in_fetch_flag  in  1  fetcher request valid (1-cycle pulse or held; sampled only in IDLE)
in_fetch_pc  in  32  requested instruction address, word aligned
out_fetch_flag  out  1  one-cycle pulse, out_fetch_inst valid
out_fetch_inst  out  32  instruction word
out_mem_flag  out  1  word-read request to memCtrl, held until in_mem_flag
out_mem_addr  out  32  word address of the current refill beat
in_mem_flag  in  1  one-cycle pulse, in_mem_data valid
in_mem_data  in  32  word returned by memCtrl
in_rob_xbp  in  1  mispredict flush

Behaviour:
- Clock, reset and ready:
  - Single clock clk; reset rst is synchronous and active-high.
  - rst=1 at a clk edge clears all valid bits, sets state to IDLE, and drives out_fetch_flag=0, out_fetch_inst=0, out_mem_flag=0, out_mem_addr=0.
  - Reset takes priority over rdy and xbp.
  - rdy=0: no register changes (valid, tag, data, state, counters, outputs all hold).
- Address split:
  - pc[1:0] ignored.
  - offset = pc[3:2].
  - index = pc[3+INDEX_WIDTH:4].
  - tag = pc[31:4+INDEX_WIDTH].
- Storage: per line, 1 valid bit, a tag, and 4 data words. A line's valid bit is set only when all 4 words are written.
- States: IDLE, REFILL, RESPOND.
- IDLE:
  - out_fetch_flag defaults to 0 each cycle.
  - On in_fetch_flag=1 and xbp=0:
    - Latch pc.
    - Hit (valid && tag match): next cycle out_fetch_flag=1 and out_fetch_inst=data[index][offset]; state stays IDLE. Hit latency is 1 cycle.
    - Miss: next cycle enter REFILL with beat=0, out_mem_flag=1, out_mem_addr={pc[31:4],4'b0}. The valid bit of the target line is cleared in the same cycle.
- REFILL:
  - out_mem_flag stays 1.
  - On in_mem_flag=1:
    - Write in_mem_data to data[index][beat].
    - If beat<3: beat++ and out_mem_addr+=4; out_mem_flag stays high, and the next beat is requested the following cycle.
    - If beat==3: write tag, set valid, drop out_mem_flag, go to RESPOND.
  - Beat order is always 0..3 from the line base; no critical-word-first.
- RESPOND:
  - Drive out_fetch_flag=1 for one cycle with out_fetch_inst=data[index][offset]. The refilled word is bypassed, so it is correct even when offset==3.
  - Return to IDLE.
- Miss latency: 1 cycle plus 4 memCtrl round trips plus 1 cycle.
- in_fetch_flag is ignored in REFILL and RESPOND. The fetcher does not issue again before out_fetch_flag.
- Flush (in_rob_xbp=1, rdy=1), in any state:
  - Next cycle: state IDLE, out_mem_flag=0, out_fetch_flag=0.
  - A partially refilled line stays invalid; its already-written words are don't-care.
  - An in_mem_flag coinciding with xbp is discarded.
  - A request coinciding with xbp in IDLE is dropped.
  - A hit response scheduled from the previous cycle is suppressed.
- Simultaneous in_mem_flag and rdy=0: the pulse is lost. memCtrl also freezes on rdy, so this does not occur in-system.
- Index wrap: lines map purely by index bits. Two PCs differing only in tag evict each other.

Test Plan:
- Cold miss, refill, respond:
  - Stimulus: after reset, request pc=0x00000008; memCtrl returns 0x11,0x22,0x33,0x44 for 0x0,0x4,0x8,0xC.
  - Required: out_mem_addr sequence 0x0,0x4,0x8,0xC; out_fetch_inst=0x33 one cycle after the last beat.
- Warm hits on the same line:
  - Stimulus: request pc=0x0, then 0xC.
  - Required: each gives out_fetch_flag 1 cycle after the request, with 0x11 then 0x44; out_mem_flag stays 0.
- Conflict eviction:
  - Stimulus: request pc=0x400 (same index 0, different tag).
  - Required: refill from 0x400..0x40C. A re-request of pc=0x0 then misses again.
- Flush mid-refill:
  - Stimulus: assert xbp during beat 2 of a miss on 0x10, with in_mem_flag coincident.
  - Required: out_mem_flag=0 next cycle and no out_fetch_flag. A later request to 0x10 misses and refills all 4 beats.
- rdy stall:
  - Stimulus: hold rdy=0 for 5 cycles between beats.
  - Required: beat counter, out_mem_addr and outputs are unchanged; the refill completes correctly after rdy=1.
- Reset mid-refill:
  - Stimulus: assert rst in REFILL.
  - Required: all outputs 0 next cycle. A request to the previously hit pc=0x0 misses.
